coeff_dequant_writer: RTL and testbench

COEFF_DEQUANT_WRITER -- requirements
Module: coeff_dequant_writer

---
 rtl/coeff_dequant_writer.sv | 181 ++++++++++++++++++
 tb/tb_coeff_dequant_writer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_dequant_writer.sv
// Coefficient dequantizer and zigzag block-buffer writer.
// Takes signed coefficients in zigzag scan order from the entropy decoder.
// Each coefficient is scaled by a frequency-band shift, and the result is
// written to the block buffer at its raster position. The module raises
// finish together with the last write of the block.
module coeff_dequant_writer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     block_mode,
  input  logic                     q_select,
  input  logic signed [8:0]        decoded_coefficient,
  input  logic                     decoded_valid,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     finish,
  output logic                     overrun
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [3:0]        row;
  logic [3:0]        col;
  logic [3:0]        row_next;
  logic [3:0]        col_next;
  logic [8:0]        count;
  logic              mode_q;
  logic              qsel_q;

  logic              start_ok;
  logic              accept;
  logic              last_coeff;
  logic [3:0]        n_max;
  logic [4:0]        diag;
  logic [1:0]        band;
  logic [2:0]        shift;
  logic [7:0]        raster;
  logic [DATA_W-1:0] coeff_ext;
  logic [DATA_W-1:0] dequant;

  // A start is only honoured from IDLE.
  // Coefficients are only taken while a block is open.
  assign start_ok = (state == IDLE) && start;
  assign accept   = (state == ACTIVE) && decoded_valid;

  // The block size, the band and the shift all come from the current scan position.
  always_comb begin
    n_max      = mode_q ? 4'd15 : 4'd7;
    diag       = {1'b0, row} + {1'b0, col};
    band       = mode_q ? 2'(diag >> 3) : 2'(diag >> 2);
    shift      = {1'b0, band} + {2'b00, qsel_q};
    last_coeff = mode_q ? (count == 9'd255) : (count == 9'd63);
    raster     = mode_q ? {row, col} : {2'b00, row[2:0], col[2:0]};
    coeff_ext  = {{(DATA_W-9){decoded_coefficient[8]}}, decoded_coefficient};
    dequant    = coeff_ext << shift;
  end

  // Next zigzag position.
  // Even diagonals move up-right and odd diagonals move down-left.
  // The scan turns along the block edges.
  always_comb begin
    row_next = row;
    col_next = col;
    if (diag[0] == 1'b0) begin
      if (col == n_max) begin
        row_next = row + 4'd1;
      end else if (row == 4'd0) begin
        col_next = col + 4'd1;
      end else begin
        row_next = row - 4'd1;
        col_next = col + 4'd1;
      end
    end else begin
      if (row == n_max) begin
        col_next = col + 4'd1;
      end else if (col == 4'd0) begin
        row_next = row + 4'd1;
      end else begin
        row_next = row + 4'd1;
        col_next = col - 4'd1;
      end
    end
  end

  // Block sequencing: IDLE -> ACTIVE -> DONE -> IDLE.
  // DONE lasts only for the finish cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)                  state_next = ACTIVE;
      ACTIVE:  if (accept && last_coeff)   state_next = DONE;
      DONE:                                state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The scan position and the coefficient count advance once per accepted coefficient.
  // They rewind on an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row   <= 4'd0;
      col   <= 4'd0;
      count <= 9'd0;
    end else if (start_ok) begin
      row   <= 4'd0;
      col   <= 4'd0;
      count <= 9'd0;
    end else if (accept) begin
      row   <= row_next;
      col   <= col_next;
      count <= count + 9'd1;
    end
  end

  // The block mode and table select are captured once per block.
  // Changes on the inputs mid-block have no effect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= 1'b0;
      qsel_q <= 1'b0;
    end else if (start_ok) begin
      mode_q <= block_mode;
      qsel_q <= q_select;
    end
  end

  // Registered write port.
  // Address and data hold their last value between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= ADDR_W'(raster);
        wr_data <= dequant;
      end
    end
  end

  // Finish is a single pulse that coincides with the write of the last coefficient.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      finish <= 1'b0;
    end else begin
      finish <= accept && last_coeff;
    end
  end

  // Sticky flag for coefficients that arrive while no block is open.
  // An accepted start clears it, but a stray coefficient in that same cycle still sets it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (decoded_valid && ((state == IDLE) || (state == DONE))) begin
      overrun <= 1'b1;
    end else if (start_ok) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_coeff_dequant_writer.sv
// Scoreboard testbench for coeff_dequant_writer.
// The expected zigzag order is built diagonal by diagonal.
// Expected writes are queued as stimulus is driven and popped when the DUT writes.
module tb_coeff_dequant_writer;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              block_mode = 1'b0;
  logic              q_select = 1'b0;
  logic signed [8:0] decoded_coefficient = '0;
  logic              decoded_valid = 1'b0;
  logic              wr_en;
  logic [7:0]        wr_addr;
  logic [15:0]       wr_data;
  logic              finish;
  logic              overrun;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              mon_e;
  int                checks_count = 0;
  int                errors_count = 0;
  int                write_count = 0;
  int                finish_count = 0;
  logic [15:0]       last_data = '0;
  int                seen[256];
  int                ord_row[256];
  int                ord_col[256];
  logic signed [8:0] coef_vals[256];

  coeff_dequant_writer #(.DATA_W(16), .ADDR_W(8)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .block_mode          (block_mode),
    .q_select            (q_select),
    .decoded_coefficient (decoded_coefficient),
    .decoded_valid       (decoded_valid),
    .wr_en               (wr_en),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .finish              (finish),
    .overrun             (overrun)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_count++;
    if (observed !== expected) begin
      errors_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Zigzag order listed per diagonal: even diagonals walk rows downward, odd ones upward
  task automatic build_order(input int n);
    int idx;
    idx = 0;
    for (int d = 0; d <= 2 * n - 2; d++) begin
      int rlo;
      int rhi;
      rlo = (d > n - 1) ? d - (n - 1) : 0;
      rhi = (d < n - 1) ? d : n - 1;
      if (d % 2 == 0) begin
        for (int r = rhi; r >= rlo; r--) begin
          ord_row[idx] = r;
          ord_col[idx] = d - r;
          idx++;
        end
      end else begin
        for (int r = rlo; r <= rhi; r++) begin
          ord_row[idx] = r;
          ord_col[idx] = d - r;
          idx++;
        end
      end
    end
  endtask

  // Monitor: every write is matched against the oldest expected entry
  always @(negedge clk) begin
    if (reset) begin
      if (wr_en) begin
        write_count++;
        last_data = wr_data;
        seen[wr_addr]++;
        checkOutput("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          checkOutput("wr_addr", wr_addr, mon_e.addr);
          checkOutput("wr_data", wr_data, mon_e.data);
          checkOutput("finish_with_write", finish, mon_e.last);
        end
      end
      if (finish) begin
        finish_count++;
        checkOutput("finish_has_write", wr_en, 1);
      end
    end
  end

  // Drives one block (possibly truncated) and queues the expected writes
  task automatic applyStimulus(input logic mode, input logic qsel, input int gap_max,
                               input int n_send, input int mid_start_at);
    int n;
    int total;
    n = mode ? 16 : 8;
    total = n * n;
    build_order(n);
    write_count = 0;
    finish_count = 0;
    for (int a = 0; a < 256; a++) seen[a] = 0;
    @(posedge clk); #1;
    start = 1'b1;
    block_mode = mode;
    q_select = qsel;
    @(posedge clk); #1;
    start = 1'b0;
    block_mode = ~mode;
    q_select = ~qsel;
    checkOutput("overrun_cleared_by_start", overrun, 0);
    for (int i = 0; i < n_send; i++) begin
      int gap;
      int r;
      int c;
      int sh;
      logic signed [15:0] v;
      exp_t e;
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gap) begin
        decoded_valid = 1'b0;
        @(posedge clk); #1;
      end
      r = ord_row[i];
      c = ord_col[i];
      sh = (mode ? (r + c) / 8 : (r + c) / 4) + (qsel ? 1 : 0);
      v = coef_vals[i];
      v = v <<< sh;
      e.addr = 8'(mode ? r * 16 + c : r * 8 + c);
      e.data = v;
      e.last = (i == total - 1);
      exp_q.push_back(e);
      decoded_valid = 1'b1;
      decoded_coefficient = coef_vals[i];
      start = (i == mid_start_at);
      @(posedge clk); #1;
      start = 1'b0;
    end
    decoded_valid = 1'b0;
  endtask

  // Waits (bounded) for the queued writes, then checks the block totals
  task automatic wait_drain(input int expected_writes, input int total_addrs);
    int k;
    int bad;
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("write_count", write_count, expected_writes);
    checkOutput("finish_count", finish_count, 1);
    bad = 0;
    for (int a = 0; a < total_addrs; a++) if (seen[a] != 1) bad++;
    checkOutput("addr_once", bad, 0);
  endtask

  initial begin
    #1;
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("rst_finish", finish, 0);
    checkOutput("rst_overrun", overrun, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_wr_en", wr_en, 0);

    // Chroma block, q_select 0, values 1..64 with no gaps between them
    for (int i = 0; i < 64; i++) coef_vals[i] = 9'(i + 1);
    applyStimulus(1'b0, 1'b0, 0, 64, -1);
    wait_drain(64, 64);
    checkOutput("chroma_last_data", last_data, 16'd512);

    // Luma block, q_select 1, all -1 with random gaps
    for (int i = 0; i < 256; i++) coef_vals[i] = -9'sd1;
    applyStimulus(1'b1, 1'b1, 5, 256, -1);
    wait_drain(256, 256);
    checkOutput("luma_last_data", last_data, 16'hFFF0);

    // Most negative coefficient at the far corner of a luma block
    for (int i = 0; i < 256; i++) coef_vals[i] = 9'sd0;
    coef_vals[255] = -9'sd256;
    applyStimulus(1'b1, 1'b1, 0, 256, -1);
    wait_drain(256, 256);
    checkOutput("min_coef_data", last_data, 16'hF000);

    // Stray coefficient while idle
    @(posedge clk); #1;
    decoded_valid = 1'b1;
    decoded_coefficient = 9'sd5;
    @(posedge clk); #1;
    decoded_valid = 1'b0;
    checkOutput("idle_no_write", wr_en, 0);
    checkOutput("overrun_set", overrun, 1);
    @(posedge clk); #1;
    checkOutput("overrun_sticky", overrun, 1);
    for (int i = 0; i < 64; i++) coef_vals[i] = 9'(i * 3 - 90);
    applyStimulus(1'b0, 1'b0, 2, 64, -1);
    wait_drain(64, 64);

    // Reset in the middle of a luma block
    for (int i = 0; i < 256; i++) coef_vals[i] = 9'((i % 7) - 3);
    applyStimulus(1'b1, 1'b0, 1, 100, -1);
    reset = 1'b0;
    #1;
    checkOutput("midrst_wr_en", wr_en, 0);
    checkOutput("midrst_wr_addr", wr_addr, 0);
    checkOutput("midrst_wr_data", wr_data, 0);
    checkOutput("midrst_finish", finish, 0);
    checkOutput("midrst_overrun", overrun, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 64; i++) coef_vals[i] = 9'(100 - i);
    applyStimulus(1'b0, 1'b1, 0, 64, -1);
    wait_drain(64, 64);

    // Start pulse during an active block must be ignored
    for (int i = 0; i < 64; i++) coef_vals[i] = 9'(i - 32);
    applyStimulus(1'b0, 1'b0, 1, 64, 20);
    wait_drain(64, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks_count, errors_count);
    $finish;
  end

  // Time limit so a stuck DUT cannot hang the run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
